// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file constants and the writeback requester encoding.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy vector for destination registers of in-flight loads, with two lookup ports.
module rf_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_idx_i,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_idx_i,
  input  logic [AW-1:0] rs1_idx_i,
  input  logic [AW-1:0] rs2_idx_i,
  output logic          rs1_busy_o,
  output logic          rs2_busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Set is applied after clear so a newly issued load to the same rd stays tracked.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy_o = busy_q[rs1_idx_i];
  assign rs2_busy_o = busy_q[rs2_idx_i];

endmodule

// File: rtl/rf_wb_sched.sv
// Register-file write-port scheduler (ALU/LSU round-robin) with load-hazard stall.
// Optional decode bypass of the pending write: define RF_WB_SCHED_BYPASS_EN.
module rf_wb_sched #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            wrt_en,
  output logic [AW-1:0]   oprd,
  output logic [XLEN-1:0] wrt_data,
  input  logic            iss_valid,
  input  logic            iss_is_load,
  input  logic [AW-1:0]   iss_rd,
  input  logic            dec_valid,
  input  logic [AW-1:0]   dec_rs1,
  input  logic [AW-1:0]   dec_rs2,
`ifdef RF_WB_SCHED_BYPASS_EN
  output logic            byp_rs1_en,
  output logic            byp_rs2_en,
  output logic [XLEN-1:0] byp_data,
`endif
  output logic            stall
);

  import rv32i_pkg::*;

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  req_e            rr_q;
  req_e            rr_d;
  logic            wrt_en_q;
  logic [AW-1:0]   oprd_q;
  logic [XLEN-1:0] wrt_data_q;

  logic contested;
  logic alu_hs;
  logic lsu_hs;
  logic set_en;
  logic rs1_busy;
  logic rs2_busy;
  logic nz1;
  logic nz2;
  logic pend1;
  logic pend2;
  logic hit1;
  logic hit2;

  // Readies are gated by rst so nothing is accepted while reset is held.
  assign contested = rst & alu_valid & lsu_valid;
  assign alu_hs    = rst & alu_valid & (~lsu_valid | (rr_q == REQ_ALU));
  assign lsu_hs    = rst & lsu_valid & (~alu_valid | (rr_q == REQ_LSU));
  assign alu_ready = alu_hs;
  assign lsu_ready = lsu_hs;

  always_comb begin
    rr_d = rr_q;
    if (contested) rr_d = (rr_q == REQ_ALU) ? REQ_LSU : REQ_ALU;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q       <= REQ_LSU;
      wrt_en_q   <= 1'b0;
      oprd_q     <= '0;
      wrt_data_q <= '0;
    end else begin
      rr_q     <= rr_d;
      wrt_en_q <= 1'b0;
      if (alu_hs) begin
        wrt_en_q   <= (alu_rd != ZERO_IDX);
        oprd_q     <= alu_rd;
        wrt_data_q <= alu_data;
      end else if (lsu_hs) begin
        wrt_en_q   <= (lsu_rd != ZERO_IDX);
        oprd_q     <= lsu_rd;
        wrt_data_q <= lsu_data;
      end
    end
  end

  assign wrt_en   = wrt_en_q;
  assign oprd     = oprd_q;
  assign wrt_data = wrt_data_q;

  assign set_en = iss_valid & iss_is_load & (iss_rd != ZERO_IDX);

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst),
    .set_en_i   (set_en),
    .set_idx_i  (iss_rd),
    .clr_en_i   (lsu_hs),
    .clr_idx_i  (lsu_rd),
    .rs1_idx_i  (dec_rs1),
    .rs2_idx_i  (dec_rs2),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy)
  );

  assign nz1   = (dec_rs1 != ZERO_IDX);
  assign nz2   = (dec_rs2 != ZERO_IDX);
  assign pend1 = wrt_en_q & (oprd_q == dec_rs1);
  assign pend2 = wrt_en_q & (oprd_q == dec_rs2);

`ifdef RF_WB_SCHED_BYPASS_EN
  // The landing write is forwarded to decode, so it no longer needs to stall.
  assign byp_rs1_en = pend1 & nz1;
  assign byp_rs2_en = pend2 & nz2;
  assign byp_data   = wrt_data_q;
  assign hit1       = nz1 & rs1_busy;
  assign hit2       = nz2 & rs2_busy;
`else
  assign hit1 = nz1 & (rs1_busy | pend1);
  assign hit2 = nz2 & (rs2_busy | pend2);
`endif

  assign stall = dec_valid & (hit1 | hit2);

endmodule

// File: tb/tb_rf_wb_sched.sv
// Bench for rf_wb_sched: per-cycle vector table plus a write-port scoreboard queue.
module tb_rf_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        wrt_en;
  logic [4:0]  oprd;
  logic [31:0] wrt_data;
  logic        iss_valid;
  logic        iss_is_load;
  logic [4:0]  iss_rd;
  logic        dec_valid;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        stall;
`ifdef RF_WB_SCHED_BYPASS_EN
  logic        byp_rs1_en;
  logic        byp_rs2_en;
  logic [31:0] byp_data;
`endif

  always #5 clk = ~clk;

  rf_wb_sched #(
    .XLEN (32),
    .NREG (32),
    .AW   (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .lsu_valid   (lsu_valid),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .lsu_ready   (lsu_ready),
    .wrt_en      (wrt_en),
    .oprd        (oprd),
    .wrt_data    (wrt_data),
    .iss_valid   (iss_valid),
    .iss_is_load (iss_is_load),
    .iss_rd      (iss_rd),
    .dec_valid   (dec_valid),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
`ifdef RF_WB_SCHED_BYPASS_EN
    .byp_rs1_en  (byp_rs1_en),
    .byp_rs2_en  (byp_rs2_en),
    .byp_data    (byp_data),
`endif
    .stall       (stall)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        iv;
    logic        il;
    logic [4:0]  ird;
    logic        dv;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_ar;
    logic        e_lr;
    logic        e_st;
    logic        e_stb;
    logic        e_b1;
    logic        e_b2;
    logic [31:0] e_bd;
  } vec_t;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  int unsigned n_tot  = 0;
  int unsigned n_pass = 0;
  int unsigned cyc    = 0;
  exp_t        exp_q[$];
  vec_t        tbl[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic vec_t mk(int av, int ard, int adat, int lv, int lrd, int ldat,
                              int iv, int il, int ird, int dv, int r1, int r2,
                              int ear, int elr, int est, int estb, int eb1, int eb2, int ebd);
    vec_t v;
    v.av = 1'(av);   v.ard = 5'(ard);  v.adat = 32'(adat);
    v.lv = 1'(lv);   v.lrd = 5'(lrd);  v.ldat = 32'(ldat);
    v.iv = 1'(iv);   v.il = 1'(il);    v.ird = 5'(ird);
    v.dv = 1'(dv);   v.r1 = 5'(r1);    v.r2 = 5'(r2);
    v.e_ar = 1'(ear); v.e_lr = 1'(elr); v.e_st = 1'(est); v.e_stb = 1'(estb);
    v.e_b1 = 1'(eb1); v.e_b2 = 1'(eb2); v.e_bd = 32'(ebd);
    return v;
  endfunction

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.cyc  = cyc + 1;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    iss_valid = 1'b0; iss_is_load = 1'b0; iss_rd = '0;
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write-port monitor: every landed write must match the next queued expectation for this cycle.
  always @(negedge clk) begin
    chk("one_grant", 32'(alu_ready & lsu_ready), 32'd0);
    if (wrt_en === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        chk("spurious_wrt_en", 32'(wrt_en), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_oprd", 32'(oprd), 32'(e.rd));
        chk("wb_data", wrt_data, e.data);
      end
    end else if (rst === 1'b1 && exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      chk("missing_wrt_en", 32'(wrt_en), 32'd1);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //       av ard adat     lv lrd ldat   iv il ird dv r1 r2  ar lr st stb b1 b2 bd
    tbl.push_back(mk(1, 1, 'h101, 1, 5, 'h205, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 'h101, 1, 6, 'h206, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 'h102, 1, 6, 'h206, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 'h102, 1, 7, 'h207, 0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 'hDEAD, 0, 0, 0,    1, 1, 0,  1, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0, 0,  1, 0, 9,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,     1, 1, 7,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0, 0,  0, 0, 7,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 7, 'h77,  0, 0, 0,     0, 0, 0,  1, 3, 7,  1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 7, 9,     1, 0, 12, 1, 12, 7, 0, 1, 1, 1, 0, 1, 'h77));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0, 0,  1, 12, 7, 0, 0, 1, 0, 0, 1, 9));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0, 0,  1, 12, 7, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,     1, 1, 4,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     1, 4, 'h44,  1, 1, 4,  1, 4, 0,  0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0, 0,  1, 4, 0,  0, 0, 1, 1, 1, 0, 'h44));
    tbl.push_back(mk(0, 0, 0,     1, 4, 'h45,  0, 0, 0,  1, 4, 0,  0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0, 0,  1, 4, 0,  0, 0, 1, 0, 1, 0, 'h45));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0, 0,  1, 4, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 13, 'h10D, 1, 14, 'h20E, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 13, 'h10D, 0, 0, 0,    0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0, 0, 0,     0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0));

    // Reset held with an ALU request pending.
    idle_inputs();
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333;
    dec_valid = 1'b1; dec_rs1 = 5'd7; dec_rs2 = 5'd10;
    repeat (2) step();
    #2;
    chk("rst alu_ready", 32'(alu_ready), 32'd0);
    chk("rst lsu_ready", 32'(lsu_ready), 32'd0);
    chk("rst wrt_en", 32'(wrt_en), 32'd0);
    chk("rst oprd", 32'(oprd), 32'd0);
    chk("rst wrt_data", wrt_data, 32'd0);
    chk("rst stall", 32'(stall), 32'd0);

    step();
    rst = 1'b1;
    dec_valid = 1'b0;
    #2;
    chk("release alu_ready", 32'(alu_ready), 32'd1);
    push_exp(5'd3, 32'h3333);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      step();
      alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
      lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ldat;
      iss_valid = v.iv; iss_is_load = v.il; iss_rd = v.ird;
      dec_valid = v.dv; dec_rs1 = v.r1; dec_rs2 = v.r2;
      if (v.e_ar && v.ard != 5'd0) push_exp(v.ard, v.adat);
      if (v.e_lr && v.lrd != 5'd0) push_exp(v.lrd, v.ldat);
      #3;
      chk($sformatf("row%0d alu_ready", i), 32'(alu_ready), 32'(v.e_ar));
      chk($sformatf("row%0d lsu_ready", i), 32'(lsu_ready), 32'(v.e_lr));
`ifdef RF_WB_SCHED_BYPASS_EN
      chk($sformatf("row%0d stall", i), 32'(stall), 32'(v.e_stb));
      chk($sformatf("row%0d byp_rs1_en", i), 32'(byp_rs1_en), 32'(v.e_b1));
      chk($sformatf("row%0d byp_rs2_en", i), 32'(byp_rs2_en), 32'(v.e_b2));
      if (v.e_b1 || v.e_b2) chk($sformatf("row%0d byp_data", i), byp_data, v.e_bd);
`else
      chk($sformatf("row%0d stall", i), 32'(stall), 32'(v.e_st));
`endif
    end

    // Mid-operation reset: busy[10] set and a write to x11 pending when reset hits.
    step();
    idle_inputs();
    iss_valid = 1'b1; iss_is_load = 1'b1; iss_rd = 5'd10;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hBB;
    dec_valid = 1'b1; dec_rs1 = 5'd10;
    #2;
    chk("mid alu_ready", 32'(alu_ready), 32'd1);
    chk("mid stall_before", 32'(stall), 32'd0);
    step();
    iss_valid = 1'b0; iss_is_load = 1'b0; alu_valid = 1'b0;
    chk("mid wrt_en_pending", 32'(wrt_en), 32'd1);
    chk("mid oprd_pending", 32'(oprd), 32'd11);
    chk("mid stall_busy10", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid rst wrt_en", 32'(wrt_en), 32'd0);
    chk("mid rst stall", 32'(stall), 32'd0);
    repeat (2) step();
    rst = 1'b1;
    dec_rs2 = 5'd11;
    #2;
    chk("mid post stall", 32'(stall), 32'd0);
    chk("mid post wrt_en", 32'(wrt_en), 32'd0);
    repeat (3) step();
    dec_valid = 1'b0;
    #5;

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Write-port scheduler and load scoreboard for the RV32I register file.
- Shares the register file's single write port (wrt_en/oprd/wrt_data) between two writeback requesters: the ALU and the load/store unit.
- Uses valid/ready handshakes with round-robin arbitration.
- Tracks destination registers of in-flight loads and raises a decode stall on read-after-write hazards.

Parameters:
- XLEN, 32, data width of the write port and the requesters.
- NREG, 32, number of architectural registers; x0 is hard-wired zero.
- AW, 5, register index width; must equal log2(NREG).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid  in  1  load writeback request.
- lsu_rd  in  AW  load destination register.
- lsu_data  in  XLEN  load data.
- lsu_ready  out  1  load request accepted this cycle.
- wrt_en  out  1  register file write enable.
- oprd  out  AW  register file write index.
- wrt_data  out  XLEN  register file write data.
- iss_valid  in  1  instruction issued this cycle.
- iss_is_load  in  1  issued instruction is a load.
- iss_rd  in  AW  issued instruction's destination register.
- dec_valid  in  1  decode stage holds a valid instruction.
- dec_rs1  in  AW  decode source register 1.
- dec_rs2  in  AW  decode source register 2.
- stall  out  1  hold decode/issue.

Behaviour:
- Reset (rst=0, asynchronous):
  - wrt_en=0, oprd=0, wrt_data=0.
  - busy vector cleared; rr_ptr=LSU.
  - A writeback in flight is discarded.
  - alu_ready/lsu_ready are combinational and read 0 during reset.
- Arbitration (combinational ready):
  - Exactly one requester valid: that requester gets ready=1.
  - Both valid: grant goes to rr_ptr; rr_ptr then flips to the other requester.
  - rr_ptr changes only on a contested grant.
  - Neither valid: both ready=0.
  - Never assert both readies in one cycle.
- Write port:
  - Registered, 1-cycle latency. A handshake at edge N drives wrt_en=1 with that rd/data during cycle N+1.
  - No handshake: wrt_en=0 next cycle; oprd/wrt_data hold their previous values.
  - rd=0: handshake still accepted, but wrt_en stays 0.
- Scoreboard (busy[NREG-1:0], busy[0] constant 0):
  - Set busy[iss_rd] on iss_valid & iss_is_load & iss_rd!=0.
  - Clear busy[lsu_rd] on an lsu handshake.
  - Set and clear of the same index in one cycle: set wins (a newer load is in flight).
  - ALU writebacks never touch busy.
- Stall (combinational): dec_valid & (hit(dec_rs1) | hit(dec_rs2)), where:
  - hit(r) = r!=0 & (busy[r] | (wrt_en & oprd==r)).
  - The pending-write term is removed when the optional feature is enabled.
- The busy bit of the LSU rd is cleared at the handshake edge. In the following cycle the pending-write term keeps the stall asserted until the write lands (without the optional feature).

Optional Feature:
- Macro: RF_WB_SCHED_BYPASS_EN.
- Defined:
  - Adds output ports byp_rs1_en (1), byp_rs2_en (1), byp_data (XLEN).
  - byp_rsN_en = wrt_en & oprd==dec_rsN & dec_rsN!=0.
  - byp_data = wrt_data.
  - The pending-write term is dropped from stall.
- Undefined: the bypass ports are absent and stall includes the pending-write term.

Decomposition:
- Shared package rv32i_pkg:
  - XLEN and AW constants.
  - REG_ZERO index constant.
  - Requester enum {REQ_ALU, REQ_LSU} used by rr_ptr.
- One sub-module, rf_scoreboard:
  - Holds the busy vector with set/clear/priority rules.
  - Two combinational lookup ports for rs1/rs2.
- Arbiter and write-port register stay in the top module.

Test Plan:
- Reset: hold rst=0 with alu_valid=1, alu_rd=3 → alu_ready=0, wrt_en=0, all busy=0. Release rst → alu_ready=1; next cycle wrt_en=1, oprd=3.
- Contention: both valid for 4 cycles (alu_rd=1..4, lsu_rd=5..8) → grants alternate LSU, ALU, LSU, ALU; oprd sequence 5, 1, 6, 2, each one cycle after its grant.
- x0: alu_valid with alu_rd=0, alu_data=32'hDEAD → alu_ready=1, wrt_en stays 0; iss load with rd=0 → busy unchanged.
- Load hazard:
  - Issue load rd=7; next cycle dec_rs2=7 → stall=1.
  - lsu handshake rd=7, data=9 → next cycle wrt_en=1, oprd=7, wrt_data=9.
  - Stall is 1 in that cycle without the macro, 0 with it (byp_rs2_en=1, byp_data=9); stall=0 from the cycle after.
- Simultaneous set/clear: iss load rd=4 in the same cycle as the lsu handshake with rd=4 → busy[4] stays 1; dec_rs1=4 keeps stall=1.
- Mid-operation reset: busy[10]=1 with a pending write to rd=11, assert rst → busy all 0, wrt_en=0 immediately; the rd=11 write is never observed after release.
